sdram_arbiter: RTL



---
 rtl/sdram_pkg.sv | 23 ++
 rtl/sdram_arbiter_if.sv | 44 ++++
 rtl/sdram_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encoding, arbiter state encoding and default bus widths.
// Latency: none (constants only).
// Backpressure: n/a.
// Imported by the arbiter and by the SDRAM controller so both use one command encoding.
package sdram_pkg;

    localparam int ADDR_W_DEF = 22;
    localparam int DATA_W_DEF = 32;

    typedef logic [1:0] cmd_t;

    // Controller command port encoding
    localparam cmd_t CMD_IDLE  = 2'd0;
    localparam cmd_t CMD_WRITE = 2'd1;
    localparam cmd_t CMD_READ  = 2'd2;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GAP   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the SDRAM arbiter.
// Latency: none (wiring only).
// Backpressure: requests are held until acked; the controller paces via valid/done strobes.
// Modports: slave = arbiter view; master = view of the requesters plus controller.
interface sdram_arbiter_if #(
    parameter int ADDR_W = sdram_pkg::ADDR_W_DEF,
    parameter int DATA_W = sdram_pkg::DATA_W_DEF
) ();

    // read requester (LCD line-buffer refill)
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_done;
    // write requester (fractal pixel writer)
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    // SDRAM controller command port
    logic [1:0]        mem_command;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write;
    logic [DATA_W-1:0] mem_read;
    logic              mem_read_valid;
    logic              mem_write_done;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
               mem_read, mem_read_valid, mem_write_done,
        output rd_ack, rd_data, rd_valid, rd_done, wr_ack,
               mem_command, mem_address, mem_write
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
               mem_read, mem_read_valid, mem_write_done,
        input  rd_ack, rd_data, rd_valid, rd_done, wr_ack,
               mem_command, mem_address, mem_write
    );

endinterface

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller command port between a burst reader and a single-word writer.
// Latency: request -> command 1 cycle; read beats forwarded 1 cycle late; wr_ack same cycle as write done.
// Backpressure: one transaction in flight; requesters hold req until ack, one GAP cycle between transactions.
// Ports: clk, rst (async active-high); bus = sdram_arbiter_if.slave (requesters + controller).
// Optional: define SDRAM_ARB_STARVE_GUARD_EN to let a waiting write win after STARVE_LIMIT read grants.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W            = ADDR_W_DEF,
    parameter int DATA_W            = DATA_W_DEF,
    parameter int READ_BURST_LENGTH = 8,
    parameter int STARVE_LIMIT      = 4
) (
    input  logic            clk,
    input  logic            rst,
    sdram_arbiter_if.slave  bus
);

    localparam int BW = $clog2(READ_BURST_LENGTH + 1);
    // Burst start is aligned down to a burst boundary
    localparam logic [ADDR_W-1:0] BURST_MASK = ADDR_W'(READ_BURST_LENGTH - 1);

    if (READ_BURST_LENGTH < 1 || READ_BURST_LENGTH > 256 ||
        (READ_BURST_LENGTH & (READ_BURST_LENGTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("sdram_arbiter: READ_BURST_LENGTH must be a power of two in 1..256, STARVE_LIMIT >= 1");
    end

    logic [1:0]        state;
    logic [BW-1:0]     beat_cnt;
    logic              pick_write;
    logic [1:0]        mem_command;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_done;

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;

    // Reads normally win; a write that has watched STARVE_LIMIT reads go by takes its turn.
    assign pick_write = bus.wr_req && (!bus.rd_req || starve_cnt == SW'(STARVE_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (pick_write)
                starve_cnt <= '0;
            else if (bus.rd_req && bus.wr_req)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end
`else
    // Strict read priority: display underrun is fatal, a delayed pixel write is not.
    assign pick_write = bus.wr_req && !bus.rd_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            beat_cnt    <= '0;
            mem_command <= CMD_IDLE;
            mem_address <= '0;
            mem_write   <= '0;
            rd_ack      <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            rd_done     <= 1'b0;
        end else begin
            rd_ack   <= 1'b0;
            rd_valid <= 1'b0;
            rd_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_write) begin
                        mem_address <= bus.wr_addr;
                        mem_write   <= bus.wr_data;
                        mem_command <= CMD_WRITE;
                        state       <= ST_WRITE;
                    end else if (bus.rd_req) begin
                        mem_address <= bus.rd_addr & ~BURST_MASK;
                        mem_command <= CMD_READ;
                        rd_ack      <= 1'b1;
                        state       <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (bus.mem_write_done) begin
                        mem_command <= CMD_IDLE;
                        state       <= ST_GAP;
                    end
                end
                ST_READ: begin
                    // Beats only count here; strays in other states are dropped.
                    if (bus.mem_read_valid) begin
                        rd_data     <= bus.mem_read;
                        rd_valid    <= 1'b1;
                        mem_command <= CMD_IDLE;
                        if (beat_cnt == BW'(READ_BURST_LENGTH - 1)) begin
                            rd_done  <= 1'b1;
                            beat_cnt <= '0;
                            state    <= ST_GAP;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                ST_GAP: begin
                    mem_command <= CMD_IDLE;
                    state       <= ST_IDLE;
                end
                default: begin
                    mem_command <= CMD_IDLE;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_command = mem_command;
    assign bus.mem_address = mem_address;
    assign bus.mem_write   = mem_write;
    assign bus.rd_ack      = rd_ack;
    assign bus.rd_data     = rd_data;
    assign bus.rd_valid    = rd_valid;
    assign bus.rd_done     = rd_done;
    assign bus.wr_ack      = (state == ST_WRITE) && bus.mem_write_done;

endmodule
